booth_r4_mult: RTL and testbench

Sequential 8×8 signed multiplier using radix-4 Booth recoding. It sequences a 2-bit arithmetic-right-shift accumulator/multiplier register pair through four add-then-shift iterations. It sits beside the ALU's combinational datapath as the MUL execution unit and talks to the ALU control FSM over a start/busy/done handshake.

---
 rtl/booth_r4_mult.sv | 113 +++++++++++
 tb/tb_booth_r4_mult.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mult.sv
// Sequential 8x8 signed radix-4 Booth multiplier (MUL unit beside the ALU).
// Optional `define BOOTH_ABORT_EN adds an abort input that cancels a multiply in flight.
module booth_r4_mult (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
`ifdef BOOTH_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  nxt;
  logic [9:0]  a_reg;
  logic [7:0]  q_reg;
  logic        qm1;
  logic [7:0]  m_reg;
  logic [1:0]  iter;
  logic [9:0]  m_ext;
  logic [9:0]  m_x2;
  logic [9:0]  digit;
  logic [9:0]  sum;
  logic [18:0] shv;
  logic        abort_req;

  // Handshake: start is a request honoured only while idle (busy=0, done=0);
  // busy covers LOAD..last SHIFT, done is a single-cycle pulse with product valid.
  assign busy      = (state == LOAD) || (state == ADD) || (state == SHIFT);
  assign done      = (state == DONE);
  assign state_dbg = state;

`ifdef BOOTH_ABORT_EN
  assign abort_req = abort & busy;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    nxt = ADD;
      ADD:     nxt = SHIFT;
      SHIFT:   nxt = (iter == 2'd3) ? DONE : ADD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort_req) nxt = IDLE;
  end

  assign m_ext = {{2{m_reg[7]}}, m_reg};
  assign m_x2  = {m_reg[7], m_reg, 1'b0};

  always_comb begin
    digit = 10'd0;
    case ({q_reg[1:0], qm1})
      3'b001, 3'b010: digit = m_ext;
      3'b011:         digit = m_x2;
      3'b100:         digit = 10'd0 - m_x2;
      3'b101, 3'b110: digit = 10'd0 - m_ext;
      default:        digit = 10'd0;
    endcase
  end

  assign sum = a_reg + digit;
  // Arithmetic right shift by two of the {A,Q,qm1} chain.
  assign shv = {a_reg[9], a_reg[9], a_reg, q_reg[7:1]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      a_reg   <= 10'd0;
      q_reg   <= 8'd0;
      qm1     <= 1'b0;
      m_reg   <= 8'd0;
      iter    <= 2'd0;
      product <= 16'h0000;
    end else begin
      state <= nxt;
      case (state)
        LOAD: begin
          a_reg <= 10'd0;
          q_reg <= multiplier;
          qm1   <= 1'b0;
          m_reg <= multiplicand;
          iter  <= 2'd0;
        end
        ADD: a_reg <= sum;
        SHIFT: begin
          a_reg <= shv[18:9];
          q_reg <= shv[8:1];
          qm1   <= shv[0];
          iter  <= iter + 2'd1;
          if (iter == 2'd3 && !abort_req) product <= {shv[16:9], shv[8:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Bench for booth_r4_mult: directed vector table, corner sequences and random
// operands checked against plain signed multiplication.
module tb_booth_r4_mult;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] p;
    int          stray;
  } vec_t;

  booth_r4_mult dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef BOOTH_ABORT_EN
    .abort        (abort),
`endif
    .busy         (busy),
    .done         (done),
    .product      (product),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] m, input logic [7:0] q);
    int r;
    r = $signed(m) * $signed(q);
    return r[15:0];
  endfunction

  // Issue one multiply; stray >= 0 re-asserts start at that cycle offset to prove it is ignored.
  task automatic do_mult(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp,
                         input int stray, input string tag);
    int lat;
    int busy_cnt;
    bit seen;
    exp_q.push_back(exp);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (lat < 30) begin
      if (lat == 1) begin
        multiplicand = 8'($urandom_range(0, 255));
        multiplier   = 8'($urandom_range(0, 255));
      end
      if (lat == stray) start = 1'b1;
      else if (lat == stray + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      // done appears in the cycle after the ninth edge following the sampling edge
      check({tag, " latency"}, 32'(lat), 32'd9);
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd9);
      check({tag, " product"}, 32'(product), 32'(exp_q.pop_front()));
    end else begin
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " idle_after"}, 32'(busy), 32'd0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  initial begin
    vec_t vecs[9];
    int nd;
    logic [7:0] rm;
    logic [7:0] rq;

    vecs[0] = '{8'd7,    8'd3,    16'h0015, -1};
    vecs[1] = '{8'h80,   8'h80,   16'h4000, -1};
    vecs[2] = '{8'h7F,   8'h80,   16'hC080, -1};
    vecs[3] = '{8'hFF,   8'hFF,   16'h0001, -1};
    vecs[4] = '{8'h5A,   8'h00,   16'h0000,  4};
    vecs[5] = '{8'h01,   8'hFF,   16'hFFFF,  9};
    vecs[6] = '{8'h80,   8'h7F,   16'hC080, -1};
    vecs[7] = '{8'h55,   8'hAA,   16'hE372, -1};
    vecs[8] = '{8'hFB,   8'h06,   16'hFFE2, -1};

    rst_b = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    multiplicand = 8'd0;
    multiplier   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'h0);
    rst_b = 1'b1;

    foreach (vecs[i]) begin
      do_mult(vecs[i].m, vecs[i].q, vecs[i].p, vecs[i].stray, $sformatf("vec%0d", i));
      if (vecs[i].stray >= 0) begin
        count_done(4, nd);
        check($sformatf("vec%0d no_requeue_done", i), 32'(nd), 32'd0);
        check($sformatf("vec%0d no_requeue_busy", i), 32'(busy), 32'd0);
      end
    end

    // Asynchronous reset during the second SHIFT of 7*3, then a fresh multiply.
    @(negedge clk);
    multiplicand = 8'd7;
    multiplier   = 8'd3;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("rst_mid in_shift", 32'(state_dbg), 32'd3);
    rst_b = 1'b0;
    #1;
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid done", 32'(done), 32'd0);
    check("rst_mid product", 32'(product), 32'h0);
    #1;
    rst_b = 1'b1;
    count_done(12, nd);
    check("rst_mid no_done", 32'(nd), 32'd0);
    do_mult(8'hFB, 8'h06, 16'hFFE2, -1, "post_rst");

`ifdef BOOTH_ABORT_EN
    do_mult(8'd7, 8'd3, 16'h0015, -1, "pre_abort");
    @(negedge clk);
    multiplicand = 8'd5;
    multiplier   = 8'd9;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("abort in_add3", 32'(state_dbg), 32'd2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort product", 32'(product), 32'h0015);
    count_done(12, nd);
    check("abort no_done", 32'(nd), 32'd0);
    check("abort product_held", 32'(product), 32'h0015);
`endif

    for (int i = 0; i < 30; i++) begin
      rm = 8'($urandom_range(0, 255));
      rq = 8'($urandom_range(0, 255));
      do_mult(rm, rq, model(rm, rq), -1, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
